// File: rtl/multi_clock_gen_if.sv
// Configuration write channel for multi_clock_gen: a valid/ready handshake
// carrying the target channel, divide, phase and enable fields.
interface multi_clock_gen_if #(
    parameter int CH_W  = 2,
    parameter int DIV_W = 4
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CH_W-1:0]  cfg_ch;
    logic [DIV_W-1:0] cfg_div;
    logic [DIV_W-1:0] cfg_phase;
    logic             cfg_en;

    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_phase, cfg_en,
        output cfg_ready
    );
endinterface

// File: rtl/multi_clock_gen.sv
// Bank of independent divided clocks driven from one master clock. New
// settings wait in a shadow copy and only take over at a period boundary.
module multi_clock_gen #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 4,
    parameter int CH_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    multi_clock_gen_if.slave  cfg,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] busy
);

    logic [DIV_W-1:0] r_div     [NUM_CH];
    logic [DIV_W-1:0] r_cnt     [NUM_CH];
    logic [DIV_W-1:0] r_shDiv   [NUM_CH];
    logic [DIV_W-1:0] r_shPhase [NUM_CH];
    logic [NUM_CH-1:0] r_en;
    logic [NUM_CH-1:0] r_shEn;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_clkOut;
    logic [NUM_CH-1:0] r_tick;

    logic              w_pendSel;
    logic [NUM_CH-1:0] w_wrEn;
    logic [NUM_CH-1:0] w_apply;
    logic [NUM_CH-1:0] w_atLimit;
    logic [DIV_W-1:0]  w_loadCnt [NUM_CH];

    // Out-of-range channel numbers match no channel, so they read as ready.
    always_comb begin
        w_pendSel = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg.cfg_ch == CH_W'(i)) begin
                w_pendSel = r_pend[i];
            end
        end
    end

    assign cfg.cfg_ready = ~w_pendSel;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            w_wrEn[i]    = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(i));
            w_atLimit[i] = (r_cnt[i] == r_div[i]);
            // A running channel swaps only on its falling edge so no phase is cut short.
            w_apply[i]   = r_pend[i] && (!r_en[i] || (w_atLimit[i] && r_clkOut[i]));
            w_loadCnt[i] = (r_shPhase[i] < r_shDiv[i]) ? r_shPhase[i] : r_shDiv[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_div[i]     <= '0;
                r_cnt[i]     <= '0;
                r_shDiv[i]   <= '0;
                r_shPhase[i] <= '0;
                r_en[i]      <= 1'b1;
                r_shEn[i]    <= 1'b0;
                r_pend[i]    <= 1'b0;
                r_clkOut[i]  <= 1'b0;
                r_tick[i]    <= 1'b0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (w_apply[i]) begin
                    r_div[i]    <= r_shDiv[i];
                    r_en[i]     <= r_shEn[i];
                    r_cnt[i]    <= w_loadCnt[i];
                    r_clkOut[i] <= 1'b0;
                    r_tick[i]   <= 1'b0;
                end else if (!r_en[i]) begin
                    r_cnt[i]    <= '0;
                    r_clkOut[i] <= 1'b0;
                    r_tick[i]   <= 1'b0;
                end else if (w_atLimit[i]) begin
                    r_cnt[i]    <= '0;
                    r_clkOut[i] <= ~r_clkOut[i];
                    r_tick[i]   <= ~r_clkOut[i];
                end else begin
                    r_cnt[i]    <= r_cnt[i] + DIV_W'(1);
                    r_tick[i]   <= 1'b0;
                end

                // A write cannot coincide with an apply: ready is low while pending.
                if (w_wrEn[i]) begin
                    r_shDiv[i]   <= cfg.cfg_div;
                    r_shPhase[i] <= cfg.cfg_phase;
                    r_shEn[i]    <= cfg.cfg_en;
                    r_pend[i]    <= 1'b1;
                end else if (w_apply[i]) begin
                    r_pend[i]    <= 1'b0;
                end
            end
        end
    end

    assign clk_out = r_clkOut;
    assign tick    = r_tick;
    assign busy    = r_pend;

endmodule

// File: tb/tb_multi_clock_gen.sv
// Scoreboard bench for multi_clock_gen: a cycle model predicts busy/tick/clk_out
// after every rising edge and each scenario task pops and compares them.
module tb_multi_clock_gen;
    localparam int NUM_CH = 4;
    localparam int DIV_W  = 4;
    localparam int CH_W   = 2;
    localparam int VW     = 3 * NUM_CH;

    logic              clock;
    logic              reset;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] busy;

    int nComp = 0;
    int nFail = 0;

    logic [VW-1:0] sbq[$];

    int mDiv[NUM_CH], mCnt[NUM_CH], sDiv[NUM_CH], sPh[NUM_CH];
    bit mEn[NUM_CH], mOut[NUM_CH], mTick[NUM_CH], mPend[NUM_CH], sEn[NUM_CH];

    multi_clock_gen_if #(.CH_W(CH_W), .DIV_W(DIV_W)) bus ();

    multi_clock_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .CH_W(CH_W)) dut (
        .clock   (clock),
        .reset   (reset),
        .cfg     (bus),
        .clk_out (clk_out),
        .tick    (tick),
        .busy    (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference model: what each channel should show after this edge.
    always @(posedge clock) begin
        int ch;
        bit acc;
        logic [NUM_CH-1:0] vp, vt, vo;
        ch  = int'(bus.cfg_ch);
        acc = bus.cfg_valid && !(ch < NUM_CH && mPend[ch]);
        if (!reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                mDiv[i] = 0; mCnt[i] = 0; mEn[i] = 1; mOut[i] = 0; mTick[i] = 0;
                mPend[i] = 0; sDiv[i] = 0; sPh[i] = 0; sEn[i] = 0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (mPend[i] && (!mEn[i] || (mCnt[i] == mDiv[i] && mOut[i]))) begin
                    mDiv[i]  = sDiv[i];
                    mEn[i]   = sEn[i];
                    mCnt[i]  = (sPh[i] < sDiv[i]) ? sPh[i] : sDiv[i];
                    mOut[i]  = 0;
                    mTick[i] = 0;
                    mPend[i] = 0;
                end else if (!mEn[i]) begin
                    mCnt[i] = 0; mOut[i] = 0; mTick[i] = 0;
                end else if (mCnt[i] == mDiv[i]) begin
                    mOut[i]  = !mOut[i];
                    mTick[i] = mOut[i];
                    mCnt[i]  = 0;
                end else begin
                    mCnt[i]  = mCnt[i] + 1;
                    mTick[i] = 0;
                end
            end
            if (acc && ch < NUM_CH) begin
                sDiv[ch]  = int'(bus.cfg_div);
                sPh[ch]   = int'(bus.cfg_phase);
                sEn[ch]   = bus.cfg_en;
                mPend[ch] = 1;
            end
        end
        for (int i = 0; i < NUM_CH; i++) begin
            vp[i] = mPend[i]; vt[i] = mTick[i]; vo[i] = mOut[i];
        end
        sbq.push_back({vp, vt, vo});
    end

    task automatic applyStimulus(input bit v, input int ch, input int dv, input int ph, input bit en);
        bus.cfg_valid = v;
        bus.cfg_ch    = CH_W'(ch);
        bus.cfg_div   = DIV_W'(dv);
        bus.cfg_phase = DIV_W'(ph);
        bus.cfg_en    = en;
    endtask

    function automatic bit expReady();
        int ch;
        ch = int'(bus.cfg_ch);
        return !(ch < NUM_CH && mPend[ch]);
    endfunction

    task automatic test_reset();
        logic [VW-1:0] exp, got;
        @(negedge clock);
        sbq.delete();
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        repeat (3) begin
            @(negedge clock);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL reset_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL reset_outs: got %h expected %h", got, exp);
                end
            end
            nComp++;
            if (bus.cfg_ready !== 1'b1) begin
                nFail++;
                $display("[TB] FAIL reset_ready: got %b expected 1", bus.cfg_ready);
            end
        end
    endtask

    task automatic test_divide_by_two();
        logic [VW-1:0] exp, got;
        @(negedge clock);
        sbq.delete();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL div2_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL div2_outs cycle %0d: got %h expected %h", k, got, exp);
                end
            end
            nComp++;
            if (clk_out !== ((k % 2 == 0) ? 4'hF : 4'h0)) begin
                nFail++;
                $display("[TB] FAIL div2_phase cycle %0d: got %h", k, clk_out);
            end
        end
    endtask

    task automatic test_reconfig_ch1();
        logic [VW-1:0] exp, got;
        @(negedge clock);
        sbq.delete();
        applyStimulus(1, 1, 2, 0, 1);
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            applyStimulus(0, 0, 0, 0, 0);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL ch1_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL ch1_outs cycle %0d: got %h expected %h", k, got, exp);
                end
            end
            if (k == 0) begin
                nComp++;
                if (busy[1] !== 1'b1) begin
                    nFail++;
                    $display("[TB] FAIL ch1_busy: got %b expected 1", busy[1]);
                end
            end
        end
    endtask

    task automatic test_mid_high_ch2();
        logic [VW-1:0] exp, got;
        bit sent;
        sent = 0;
        @(negedge clock);
        sbq.delete();
        for (int k = 0; k < 24; k++) begin
            @(negedge clock);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL ch2_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL ch2_outs cycle %0d: got %h expected %h", k, got, exp);
                end
            end
            if (!sent && mOut[2]) begin
                applyStimulus(1, 2, 3, 0, 1);
                sent = 1;
            end else begin
                applyStimulus(0, 0, 0, 0, 0);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [VW-1:0] exp, got;
        int stage, stalls;
        stage = 0;
        stalls = 0;
        @(negedge clock);
        sbq.delete();
        applyStimulus(1, 0, 3, 0, 1);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL b2b_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL b2b_outs cycle %0d: got %h expected %h", k, got, exp);
                end
            end
            if (stage == 0) begin
                applyStimulus(1, 0, 1, 0, 1);
                stage = 1;
            end else if (stage == 2) begin
                applyStimulus(0, 0, 0, 0, 0);
                stage = 3;
            end
            #1;
            if (stage == 1) begin
                nComp++;
                if (bus.cfg_ready !== expReady()) begin
                    nFail++;
                    $display("[TB] FAIL b2b_ready cycle %0d: got %b expected %b", k, bus.cfg_ready, expReady());
                end
                if (expReady()) stage = 2;
                else stalls++;
            end
        end
        nComp++;
        if (stage != 3 || stalls == 0) begin
            nFail++;
            $display("[TB] FAIL b2b_stall: stage %0d stalls %0d, expected stage 3 with stalls", stage, stalls);
        end
    endtask

    task automatic test_disable_reenable();
        logic [VW-1:0] exp, got;
        int stage;
        stage = 0;
        @(negedge clock);
        sbq.delete();
        applyStimulus(1, 3, 0, 0, 0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL dis_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL dis_outs cycle %0d: got %h expected %h", k, got, exp);
                end
            end
            applyStimulus(0, 0, 0, 0, 0);
            if (stage == 0 && !mEn[3] && !mPend[3]) begin
                stage = 1;
            end else if (stage >= 1 && stage < 4) begin
                nComp++;
                if (clk_out[3] !== 1'b0) begin
                    nFail++;
                    $display("[TB] FAIL dis_hold: got %b expected 0", clk_out[3]);
                end
                stage++;
                if (stage == 4) applyStimulus(1, 3, 1, 1, 1);
            end
        end
        nComp++;
        if (stage != 4 || !mEn[3]) begin
            nFail++;
            $display("[TB] FAIL dis_progress: stage %0d en %0d expected 4 and 1", stage, mEn[3]);
        end
    endtask

    task automatic test_reset_mid_pending();
        logic [VW-1:0] exp, got;
        @(negedge clock);
        sbq.delete();
        applyStimulus(1, 1, 5, 0, 1);
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL rstmid_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL rstmid_outs cycle %0d: got %h expected %h", k, got, exp);
                end
            end
            if (k == 1) begin
                nComp++;
                if (got !== '0) begin
                    nFail++;
                    $display("[TB] FAIL rstmid_zero: got %h expected 0", got);
                end
            end
            applyStimulus(0, 0, 0, 0, 0);
            reset = (k == 0) ? 1'b0 : 1'b1;
        end
    endtask

    task automatic test_random();
        logic [VW-1:0] exp, got;
        @(negedge clock);
        sbq.delete();
        for (int k = 0; k < 120; k++) begin
            @(negedge clock);
            got = {busy, tick, clk_out};
            nComp++;
            if (sbq.size() == 0) begin
                nFail++;
                $display("[TB] FAIL rand_sb: no expected entry, got %h", got);
            end else begin
                exp = sbq.pop_front();
                if (got !== exp) begin
                    nFail++;
                    $display("[TB] FAIL rand_outs cycle %0d: got %h expected %h", k, got, exp);
                end
            end
            applyStimulus($urandom_range(0, 2) == 0, int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                          $urandom_range(0, 4) != 0);
            #1;
            nComp++;
            if (bus.cfg_ready !== expReady()) begin
                nFail++;
                $display("[TB] FAIL rand_ready cycle %0d: got %b expected %b", k, bus.cfg_ready, expReady());
            end
        end
        applyStimulus(0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0);
        test_reset();
        test_divide_by_two();
        test_reconfig_ch1();
        test_mid_high_ch2();
        test_back_to_back();
        test_disable_reenable();
        test_reset_mid_pending();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nComp, nFail);
        $finish;
    end
endmodule

// File: doc/multi_clock_gen.md
MULTI_CLOCK_GEN -- requirements
Module: multi_clock_gen

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 4, giving the number of independent divided-clock channels (1..16).
REQ-002 The block SHALL have parameter DIV_W, default 4, giving the width of the divide and phase fields.
REQ-003 The block SHALL have parameter CH_W, default 2, giving the channel-select width; CH_W = max(1, clog2(NUM_CH)).
REQ-004 clock  input  1  single master clock; all state SHALL update on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
REQ-006 cfg_valid  input  1  configuration write request.
REQ-007 cfg_ready  output  1  config accept; a write transfers on a rising edge where cfg_valid=1 and cfg_ready=1.
REQ-008 cfg_ch  input  CH_W  target channel; values >= NUM_CH SHALL be accepted and ignored.
REQ-009 cfg_div  input  DIV_W  half-period minus one; the channel period SHALL be 2*(cfg_div+1) clock cycles.
REQ-010 cfg_phase  input  DIV_W  initial count loaded when a new configuration is applied.
REQ-011 cfg_en  input  1  channel run enable.
REQ-012 clk_out  output  NUM_CH  registered divided clocks, one bit per channel.
REQ-013 tick  output  NUM_CH  registered one-cycle pulse, high in the cycle clk_out[i] first reads 1 in each period.
REQ-014 busy  output  NUM_CH  high while channel i holds an accepted but unapplied configuration.

Function
REQ-015 Each channel SHALL hold active registers div, phase, en and cnt, plus shadow registers and a pending flag.
REQ-016 cfg_ready SHALL be combinational: 1 when cfg_ch >= NUM_CH or pending[cfg_ch]=0; otherwise 0.
REQ-017 An accepted write to a valid channel SHALL load that channel's shadow registers and set pending; busy[i] SHALL read 1 from the next cycle.
REQ-018 An enabled channel SHALL count as follows: cnt increments each cycle; when cnt=div, cnt <= 0 and clk_out toggles.
REQ-019 tick[i] SHALL be 1 in exactly the cycle in which clk_out[i] transitions 0->1, and 0 in all other cycles.
REQ-020 Period boundary: a pending config on an enabled channel SHALL apply only on the edge where clk_out goes 1->0 (cnt=div, clk_out=1), so no high or low phase is ever shortened.
REQ-021 Apply action: div, phase and en SHALL load from the shadow registers; cnt <= min(phase, new div); clk_out <= 0; pending and busy SHALL clear.
REQ-022 A pending config on a disabled channel SHALL apply on the next rising edge.
REQ-023 A disabled channel SHALL hold clk_out=0, tick=0 and cnt=0.
REQ-024 Disabling a running channel SHALL take effect at its period boundary per REQ-020; its output therefore SHALL end low after a full period.
REQ-025 Channels SHALL be fully independent; configuring one channel SHALL NOT perturb the count or output of any other channel.
REQ-026 When an apply and a new accepted write to the same channel occur in the same cycle, the apply SHALL win; the write cannot occur because cfg_ready=0.
REQ-027 All outputs except cfg_ready SHALL be registered and glitch-free.

Reset
REQ-028 While reset=0 at a rising edge, every channel SHALL take div=0, phase=0, en=1, cnt=0, pending=0, clk_out=0 and tick=0; busy SHALL read all 0 and cfg_ready SHALL read 1.
REQ-029 Reset asserted mid-period or mid-pending SHALL discard all counts and shadow configuration, returning the state of REQ-028 on the next edge.
REQ-030 On the first edge after reset deasserts, all channels SHALL run in phase: clk_out all 1 and tick all 1.

Verification
REQ-031 Release reset -> every channel reads clk_out 1,0,1,0 on successive cycles, with tick on each 1.
REQ-032 Write ch1 div=2 phase=0 en=1 -> busy[1]=1 until the next 1->0 edge; then ch1 gives 3 cycles low and 3 cycles high, repeating, with a tick every 6 cycles; ch0, ch2 and ch3 are unchanged.
REQ-033 Write ch2 div=3 while ch2 is mid-high -> no high or low phase shorter than 1 cycle is seen; the new period of 8 starts exactly at the 1->0 edge.
REQ-034 Write ch0 div=3, then issue a second write to ch0 while busy[0]=1 -> cfg_ready=0 and the second write stalls; it is accepted on the cycle after the apply.
REQ-035 Write ch3 en=0, then write en=1 div=1 phase=1 -> ch3 ends low after its period and holds 0; it re-enables the next cycle with cnt=1, so the first low phase is 1 cycle and subsequent phases are 2 cycles each.
REQ-036 Drive reset=0 while ch1 is pending with div=5 -> the next edge gives all outputs 0 and busy=0; after release, all channels return to divide-by-2 in phase.
